// File: rtl/rle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rle_pkg
// Description : Shared RLE types and constants (escape code, FSM states, byte).
// Revision    : 1.0 - initial release
// ============================================================================
package rle_pkg;

    typedef logic [7:0] rle_byte_t;

    localparam rle_byte_t ESC = 8'h1B;

    typedef enum logic [1:0] {
        LIT     = 2'd0,
        GOT_ESC = 2'd1,
        GOT_CNT = 2'd2,
        EXPAND  = 2'd3
    } rle_state_e;

endpackage : rle_pkg
`default_nettype wire

// File: rtl/rle_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rle_decoder_if
// Description : Encoded-byte input and decoded-byte output handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rle_decoder_if;
    import rle_pkg::*;

    rle_byte_t Data_In;
    logic      Data_valid_in;
    logic      in_ready;
    rle_byte_t Data_out;
    logic      Data_valid;
    logic      out_ready;
    logic      overflow;
    logic      err;

    modport master (
        output Data_In, Data_valid_in, out_ready,
        input  in_ready, Data_out, Data_valid, overflow, err
    );

    modport slave (
        input  Data_In, Data_valid_in, out_ready,
        output in_ready, Data_out, Data_valid, overflow, err
    );

endinterface : rle_decoder_if
`default_nettype wire

// File: rtl/rle_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rle_byte_fifo
// Description : Single-clock byte FIFO, fall-through read, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rle_byte_fifo
    import rle_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire       clk,
    input  wire       rst,
    input  wire       push_i,
    input  wire       pop_i,
    input  rle_byte_t din_i,
    output rle_byte_t dout_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = {{AW{1'b0}}, 1'b1};

    rle_byte_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    // Extra MSB on each pointer tells full apart from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule : rle_byte_fifo
`default_nettype wire

// File: rtl/rle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rle_decoder
// Description : Expands literal bytes and ESC,count,data triples into bytes.
//               Optional count-0/count-2 error flag: RLE_DEC_ERR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rle_decoder #(
    parameter int         DEPTH = 8,
    parameter logic [7:0] ESC   = 8'h1B
) (
    input  wire           data_clock,
    input  wire           reset,
    rle_decoder_if.slave  bus
);
    import rle_pkg::*;

    rle_state_e state_q, state_d;
    rle_byte_t  data_out_q, data_out_d;
    logic       valid_q, valid_d;
    rle_byte_t  run_cnt_q, run_cnt_d;
    rle_byte_t  run_data_q, run_data_d;
    logic       overflow_q, overflow_d;

    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    rle_byte_t  fifo_dout;
    logic       out_free;
    logic       can_pop;

    assign out_free = !valid_q || bus.out_ready;
    assign can_pop  = !fifo_empty && out_free;

    // A full FIFO still takes a byte when a pop frees a slot on the same edge.
    assign fifo_push  = bus.Data_valid_in && (!fifo_full || fifo_pop);
    assign overflow_d = overflow_q | (bus.Data_valid_in && fifo_full && !fifo_pop);

    rle_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (data_clock),
        .rst     (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (bus.Data_In),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef RLE_DEC_ERR_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        run_cnt_d  = run_cnt_q;
        run_data_d = run_data_q;
        fifo_pop   = 1'b0;
`ifdef RLE_DEC_ERR_CHECK_EN
        err_d      = err_q;
`endif
        if (valid_q && bus.out_ready) valid_d = 1'b0;

        case (state_q)
            LIT: begin
                if (can_pop) begin
                    fifo_pop = 1'b1;
                    if (fifo_dout == ESC) begin
                        state_d = GOT_ESC;
                    end else begin
                        data_out_d = fifo_dout;
                        valid_d    = 1'b1;
                    end
                end
            end
            GOT_ESC: begin
                if (can_pop) begin
                    fifo_pop  = 1'b1;
                    run_cnt_d = fifo_dout;
                    state_d   = GOT_CNT;
                end
            end
            GOT_CNT: begin
                if (can_pop) begin
                    fifo_pop   = 1'b1;
                    run_data_d = fifo_dout;
`ifdef RLE_DEC_ERR_CHECK_EN
                    if (run_cnt_q == 8'd0 || run_cnt_q == 8'd2) err_d = 1'b1;
`endif
                    // First copy leaves with the data byte; run_cnt tracks the rest.
                    if (run_cnt_q == 8'd0) begin
                        state_d = LIT;
                    end else begin
                        data_out_d = fifo_dout;
                        valid_d    = 1'b1;
                        run_cnt_d  = run_cnt_q - 8'd1;
                        state_d    = (run_cnt_q == 8'd1) ? LIT : EXPAND;
                    end
                end
            end
            EXPAND: begin
                if (out_free) begin
                    data_out_d = run_data_q;
                    valid_d    = 1'b1;
                    run_cnt_d  = run_cnt_q - 8'd1;
                    if (run_cnt_q == 8'd1) state_d = LIT;
                end
            end
            default: state_d = LIT;
        endcase
    end

    always_ff @(posedge data_clock or posedge reset) begin
        if (reset) begin
            state_q    <= LIT;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            run_cnt_q  <= '0;
            run_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            run_cnt_q  <= run_cnt_d;
            run_data_q <= run_data_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef RLE_DEC_ERR_CHECK_EN
    always_ff @(posedge data_clock or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready   = !fifo_full;
    assign bus.Data_out   = data_out_q;
    assign bus.Data_valid = valid_q;
    assign bus.overflow   = overflow_q;

endmodule : rle_decoder
`default_nettype wire
